// File: rtl/sfft_readout_pkg.sv
// Shared definitions for the SFFT readout bridge: register offsets, control/status bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Offsets are byte offsets relative to the end of the bin region (N_BINS*4).
package sfft_readout_pkg;

    localparam int OFS_CNT    = 0;   // frame counter, 4 bytes little-endian
    localparam int OFS_STATUS = 4;   // status byte
    localparam int OFS_DROP   = 8;   // drop counter, 4 bytes little-endian

    // Control byte bits
    localparam int CTRL_LOCK_BIT    = 0;
    localparam int CTRL_CLR_OVR_BIT = 1;

    // Status byte bits
    localparam int ST_READY_BIT   = 0;
    localparam int ST_LOCK_BIT    = 1;
    localparam int ST_OVERRUN_BIT = 2;

    typedef struct packed {
        logic [4:0] rsvd;
        logic       overrun;
        logic       lock;
        logic       ready;
    } status_t;

    // Little-endian byte pick from a 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
        return w[8*sel +: 8];
    endfunction

endpackage

// File: rtl/readout_bank_ram.sv
// Simple dual-port bin store, two banks selected by the address MSB.
// Latency: write lands at the clock edge; read data is registered, 1 cycle after rd_addr.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data registered read port.
// Contents are deliberately not reset; the bridge masks stale data with its ready flag.
module readout_bank_ram
    import sfft_readout_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sfft_readout_bridge.sv
// Ping-pong capture of SFFT bin frames, served to an 8-bit memory-mapped bus as LE bytes.
// Latency: readdata reflects address of the previous cycle; frame swap 1 cycle after frame_done.
// Backpressure: none; frames completing while software holds the lock are dropped and counted.
//
// Ports: clk, reset (async active-high); bin_valid/bin_index/bin_data/frame_done from the
// pipeline; chipselect/write/address/writedata/readdata bus.
// Build option: define READOUT_DROP_CNT_EN to implement the drop counter register.
module sfft_readout_bridge
    import sfft_readout_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int N_BINS = 256,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bin_valid,
    input  logic [$clog2(N_BINS)-1:0] bin_index,
    input  logic [WORD_W-1:0]         bin_data,
    input  logic                      frame_done,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         address,
    input  logic [7:0]                writedata,
    output logic [7:0]                readdata
);

    localparam int IDX_W      = $clog2(N_BINS);
    localparam int BIN_BYTES  = N_BINS * 4;
    localparam int WORD_BYTES = WORD_W / 8;

    logic             bank_sel;   // bank currently visible to the bus
    logic             lock_q;
    logic             ready_q;
    logic             overrun_q;
    logic [CNT_W-1:0] frame_cnt;

    logic bus_wr;
    logic eff_lock;
    logic bin_we;
    logic swap;
    logic drop;

    assign bus_wr   = chipselect && write;
    // A lock write in the same cycle as frame_done already governs that frame.
    assign eff_lock = bus_wr ? writedata[CTRL_LOCK_BIT] : lock_q;
    assign bin_we   = bin_valid && (32'(bin_index) < 32'(N_BINS));
    assign swap     = frame_done && !eff_lock;
    assign drop     = frame_done && eff_lock;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel  <= 1'b0;
            lock_q    <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (bus_wr) begin
                lock_q <= writedata[CTRL_LOCK_BIT];
            end
            if (swap) begin
                bank_sel  <= ~bank_sel;
                frame_cnt <= frame_cnt + CNT_W'(1);
                ready_q   <= 1'b1;
            end
            // Setting wins over a simultaneous software clear.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (bus_wr && writedata[CTRL_CLR_OVR_BIT]) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef READOUT_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`endif

    // Bins go to the back bank; in the frame_done cycle bank_sel is still the old value,
    // so a bin arriving with frame_done joins the frame being published.
    logic [WORD_W-1:0] ram_rdata;

    readout_bank_ram #(
        .WORD_W (WORD_W),
        .AW     (IDX_W + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (bin_we),
        .wr_addr ({~bank_sel, bin_index}),
        .wr_data (bin_data),
        .rd_addr ({bank_sel, address[IDX_W+1:2]}),
        .rd_data (ram_rdata)
    );

    // Read decode in the address cycle; register values are captured alongside the RAM read
    // so both paths present their byte in the following cycle.
    logic [31:0] addr32;
    logic [31:0] cnt32;
    status_t     status;
    logic        rd_bin;
    logic [7:0]  rd_byte;
    logic        rd_bin_q;
    logic [1:0]  rd_bsel_q;
    logic [7:0]  rd_byte_q;

    assign addr32 = 32'(address);
    assign cnt32  = 32'(frame_cnt);

    always_comb begin
        status         = '0;
        status.overrun = overrun_q;
        status.lock    = lock_q;
        status.ready   = ready_q;
    end

    always_comb begin
        rd_bin  = 1'b0;
        rd_byte = 8'h00;
        if (addr32 < 32'(BIN_BYTES)) begin
            rd_bin = ready_q && (32'(address[1:0]) < 32'(WORD_BYTES));
        end else if ((addr32 >= 32'(BIN_BYTES + OFS_CNT)) &&
                     (addr32 <  32'(BIN_BYTES + OFS_CNT + 4))) begin
            rd_byte = byte_of(cnt32, address[1:0]);
        end else if (addr32 == 32'(BIN_BYTES + OFS_STATUS)) begin
            rd_byte = status;
`ifdef READOUT_DROP_CNT_EN
        end else if ((addr32 >= 32'(BIN_BYTES + OFS_DROP)) &&
                     (addr32 <  32'(BIN_BYTES + OFS_DROP + 4))) begin
            rd_byte = byte_of(32'(drop_cnt), address[1:0]);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bin_q  <= 1'b0;
            rd_bsel_q <= 2'd0;
            rd_byte_q <= 8'h00;
        end else begin
            rd_bin_q  <= rd_bin;
            rd_bsel_q <= address[1:0];
            rd_byte_q <= rd_byte;
        end
    end

    assign readdata = rd_bin_q ? byte_of(32'(ram_rdata), rd_bsel_q) : rd_byte_q;

    logic unused_wdata;
    assign unused_wdata = ^writedata[7:2];

endmodule

// File: tb/tb_sfft_readout_bridge.sv
// Randomized bench for sfft_readout_bridge against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_sfft_readout_bridge;

    localparam int WORD_W    = 32;
    localparam int N_BINS    = 256;
    localparam int ADDR_W    = 16;
    localparam int CNT_W     = 32;
    localparam int IDX_W     = $clog2(N_BINS);
    localparam int BIN_BYTES = N_BINS * 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              bin_valid;
    logic [IDX_W-1:0]  bin_index;
    logic [WORD_W-1:0] bin_data;
    logic              frame_done;
    logic              chipselect;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [7:0]        writedata;
    logic [7:0]        readdata;

    always #5 clk = ~clk;

    sfft_readout_bridge #(
        .WORD_W (WORD_W),
        .N_BINS (N_BINS),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bin_valid  (bin_valid),
        .bin_index  (bin_index),
        .bin_data   (bin_data),
        .frame_done (frame_done),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two frame buffers, which one software sees, and the register set.
    logic [WORD_W-1:0] m_mem [2][N_BINS];
    int                m_front;
    bit                m_ready, m_lock, m_ovr;
    logic [CNT_W-1:0]  m_cnt, m_drop;
    logic [WORD_W-1:0] last_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_front = 0;
        m_ready = 1'b0;
        m_lock  = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = '0;
        m_drop  = '0;
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        int k, b;
        if (a < BIN_BYTES) begin
            if (!m_ready) return 8'h00;
            k = a / 4;
            b = a % 4;
            if (b >= WORD_W / 8) return 8'h00;
            return 8'(m_mem[m_front][k] >> (8 * b));
        end
        if (a >= BIN_BYTES && a < BIN_BYTES + 4) return 8'(64'(m_cnt) >> (8 * (a - BIN_BYTES)));
        if (a == BIN_BYTES + 4) return {5'b0, m_ovr, m_lock, m_ready};
`ifdef READOUT_DROP_CNT_EN
        if (a >= BIN_BYTES + 8 && a < BIN_BYTES + 12) return 8'(64'(m_drop) >> (8 * (a - BIN_BYTES - 8)));
`endif
        return 8'h00;
    endfunction

    task automatic model_step(input bit bv, input int idx, input logic [WORD_W-1:0] d,
                              input bit fd, input bit wr, input logic [7:0] wd);
        bit el;
        if (bv && idx < N_BINS) m_mem[1 - m_front][idx] = d;
        el = wr ? wd[0] : m_lock;
        if (fd && !el) begin
            m_front = 1 - m_front;
            m_cnt   = m_cnt + 1'b1;
            m_ready = 1'b1;
        end
        if (wr) begin
            m_lock = wd[0];
            if (wd[1]) m_ovr = 1'b0;
        end
        if (fd && el) begin
            m_ovr = 1'b1;
            if (m_drop != '1) m_drop = m_drop + 1'b1;
        end
    endtask

    // One clock of stimulus; optionally checks the byte read for this cycle's address.
    task automatic cyc(input bit bv, input int idx, input logic [WORD_W-1:0] d, input bit fd,
                       input bit wr, input logic [7:0] wd, input int a, input bit do_chk,
                       input string tag);
        logic [7:0] e;
        @(negedge clk);
        bin_valid  = bv;
        bin_index  = IDX_W'(idx);
        bin_data   = d;
        frame_done = fd;
        chipselect = wr;
        write      = wr;
        writedata  = wd;
        address    = ADDR_W'(a);
        e = exp_byte(a);
        model_step(bv, idx, d, fd, wr, wd);
        @(posedge clk);
        #1;
        if (do_chk) chk(tag, 32'(readdata), 32'(e));
        bin_valid  = 1'b0;
        frame_done = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input int a, input string tag, output logic [7:0] v);
        cyc(1'b0, 0, '0, 1'b0, 1'b0, 8'h00, a, 1'b1, tag);
        v = readdata;
    endtask

    task automatic wr_ctrl(input logic [7:0] wd);
        cyc(1'b0, 0, '0, 1'b0, 1'b1, wd, 0, 1'b0, "");
    endtask

    task automatic done_pulse();
        cyc(1'b0, 0, '0, 1'b1, 1'b0, 8'h00, 0, 1'b0, "");
    endtask

    // Full frame of bins; pat selects the 0x0A0B0C00+k pattern, fd_last merges frame_done.
    task automatic stream(input bit pat, input bit fd_last);
        for (int k = 0; k < N_BINS; k++) begin
            logic [WORD_W-1:0] d;
            d = pat ? WORD_W'(32'h0A0B0C00 + k) : WORD_W'($urandom);
            if ($urandom_range(0, 15) == 0) cyc(1'b0, 0, '0, 1'b0, 1'b0, 8'h00, 0, 1'b0, "");
            cyc(1'b1, k, d, fd_last && (k == N_BINS - 1), 1'b0, 8'h00, 0, 1'b0, "");
            last_word = d;
        end
    endtask

    task automatic sample_bins(input int n, input string tag);
        logic [7:0] v;
        for (int i = 0; i < n; i++) rd($urandom_range(0, BIN_BYTES - 1), tag, v);
    endtask

    task automatic sweep(input string tag);
        logic [7:0] v;
        for (int a = 0; a < BIN_BYTES + 16; a++) rd(a, $sformatf("%s_%0d", tag, a), v);
    endtask

    task automatic drop_const(input string tag, input logic [31:0] exp_drop);
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            rd(BIN_BYTES + 8 + i, tag, v);
`ifdef READOUT_DROP_CNT_EN
            chk($sformatf("%s_c%0d", tag, i), 32'(v), 32'(8'(exp_drop >> (8 * i))));
`else
            chk($sformatf("%s_c%0d", tag, i), 32'(v), 32'h0);
`endif
        end
    endtask

    initial begin
        logic [7:0] v;
        int         a;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < N_BINS; k++) m_mem[b][k] = '0;
        reset = 1'b1;
        bin_valid = 1'b0; bin_index = '0; bin_data = '0; frame_done = 1'b0;
        chipselect = 1'b0; write = 1'b0; address = '0; writedata = 8'h00;
        last_word = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_readdata", 32'(readdata), 32'h0);
        rd(BIN_BYTES + 4, "rst_status", v);
        chk("rst_status_c", 32'(v), 32'h00);
        rd(0, "rst_bin0", v);
        chk("rst_bin0_c", 32'(v), 32'h00);

        // First frame, fixed pattern
        stream(1'b1, 1'b0);
        done_pulse();
        rd(BIN_BYTES + 4, "f1_status", v);
        chk("f1_status_c", 32'(v), 32'h01);
        rd(4 * 5 + 0, "f1_b20", v);
        chk("f1_b20_c", 32'(v), 32'h05);
        rd(4 * 5 + 3, "f1_b23", v);
        chk("f1_b23_c", 32'(v), 32'h0A);
        for (int i = 0; i < 4; i++) begin
            rd(BIN_BYTES + i, "f1_cnt", v);
            chk($sformatf("f1_cnt_c%0d", i), 32'(v), (i == 0) ? 32'h01 : 32'h00);
        end
        sweep("f1_sweep");

        // Lock, three dropped frames
        wr_ctrl(8'h01);
        repeat (3) begin
            stream(1'b0, 1'b0);
            done_pulse();
        end
        rd(BIN_BYTES + 4, "lk_status", v);
        chk("lk_status_c", 32'(v), 32'h07);
        rd(4 * 5 + 0, "lk_b20", v);
        chk("lk_b20_c", 32'(v), 32'h05);
        drop_const("lk_drop", 32'd3);
        sample_bins(16, "lk_bins");
        wr_ctrl(8'h02);
        rd(BIN_BYTES + 4, "ul_status", v);
        chk("ul_status_c", 32'(v), 32'h01);
        stream(1'b0, 1'b0);
        done_pulse();
        rd(BIN_BYTES, "ul_cnt0", v);
        chk("ul_cnt0_c", 32'(v), 32'h02);
        sample_bins(16, "ul_bins");

        // Lock write coinciding with frame_done drops it; unlock coinciding swaps
        stream(1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b1, 8'h01, 0, 1'b0, "");
        rd(BIN_BYTES + 4, "sc_lock_status", v);
        chk("sc_lock_status_c", 32'(v), 32'h07);
        drop_const("sc_drop", 32'd4);
        cyc(1'b0, 0, '0, 1'b1, 1'b1, 8'h00, 0, 1'b0, "");
        rd(BIN_BYTES + 4, "sc_unlock_status", v);
        chk("sc_unlock_status_c", 32'(v), 32'h05);
        rd(BIN_BYTES, "sc_cnt0", v);
        chk("sc_cnt0_c", 32'(v), 32'h03);
        sample_bins(16, "sc_bins");
        // Clear coinciding with a locked frame_done: overrun must stay
        cyc(1'b0, 0, '0, 1'b1, 1'b1, 8'h03, 0, 1'b0, "");
        rd(BIN_BYTES + 4, "setwins_status", v);
        chk("setwins_status_c", 32'(v), 32'h07);
        wr_ctrl(8'h02);
        rd(BIN_BYTES + 4, "clr_status", v);
        chk("clr_status_c", 32'(v), 32'h01);

        // Read in the frame_done cycle sees the old front bank
        stream(1'b0, 1'b0);
        a = $urandom_range(0, N_BINS - 1) * 4;
        cyc(1'b0, 0, '0, 1'b1, 1'b0, 8'h00, a, 1'b1, "fd_cycle_read");
        rd(a, "after_swap_read", v);

        // Last bin arriving with frame_done is part of the published frame
        stream(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd(4 * (N_BINS - 1) + i, "lastbin", v);
            chk($sformatf("lastbin_c%0d", i), 32'(v), 32'(8'(last_word >> (8 * i))));
        end

        // Back-to-back frame_done pulses, unlocked then locked
        repeat (4) done_pulse();
        sample_bins(8, "b2b_bins");
        rd(BIN_BYTES, "b2b_cnt0", v);
        wr_ctrl(8'h01);
        repeat (3) done_pulse();
        rd(BIN_BYTES + 4, "b2b_lk_status", v);
        drop_const("b2b_drop", 32'd8);
        wr_ctrl(8'h02);

        // Random reads across the map and the whole address space
        for (int i = 0; i < 40; i++) begin
            a = (i % 2 == 0) ? $urandom_range(0, BIN_BYTES + 15) : $urandom_range(0, (1 << ADDR_W) - 1);
            rd(a, "rand_rd", v);
        end

        // Asynchronous reset in the middle of a frame
        for (int k = 0; k < 100; k++) cyc(1'b1, k, WORD_W'($urandom), 1'b0, 1'b0, 8'h00, 4 * 5, 1'b0, "");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_readdata", 32'(readdata), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(BIN_BYTES + 4, "rst2_status", v);
        chk("rst2_status_c", 32'(v), 32'h00);
        rd(4 * 5, "rst2_bin", v);
        chk("rst2_bin_c", 32'(v), 32'h00);
        stream(1'b0, 1'b0);
        done_pulse();
        for (int i = 0; i < 4; i++) begin
            rd(BIN_BYTES + i, "rst2_cnt", v);
            chk($sformatf("rst2_cnt_c%0d", i), 32'(v), (i == 0) ? 32'h01 : 32'h00);
        end
        drop_const("rst2_drop", 32'd0);
        sweep("rst2_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sfft_readout_bridge.md
# sfft_readout_bridge

Double-buffered readout bridge between the SFFT pipeline's streaming bin output and the 8-bit memory-mapped driver bus. It captures each completed spectrum frame into a ping-pong bin store, stamps it with a frame counter, and serves bins, counter and status to software as little-endian bytes. Software locks a frame for a race-free read while the pipeline keeps running; frames finishing during the lock are dropped and counted.

## Interface
Parameters:
- WORD_W, 32: bin word width; multiple of 8, 8..32.
- N_BINS, 256: bins per frame; power of two, 16..1024.
- ADDR_W, 16: bus byte-address width; must satisfy 2^ADDR_W >= N_BINS*4+16.
- CNT_W, 32: frame and drop counter width, 8..32.

Ports:
- clk, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- bin_valid, in, 1: bin_data/bin_index valid this cycle.
- bin_index, in, $clog2(N_BINS): bin slot.
- bin_data, in, WORD_W: bin magnitude.
- frame_done, in, 1: one-cycle pulse marking the frame complete.
- chipselect, in, 1: bus select.
- write, in, 1: bus write strobe.
- address, in, ADDR_W: byte address.
- writedata, in, 8: control byte.
- readdata, out, 8: registered read byte.

## Operation
- Two banks: back bank (written by pipeline), front bank (read by bus). bank_sel register chooses which is front.
- Valid bins write the back bank at bin_index; bin_index >= N_BINS is ignored (only possible if N_BINS is not a power of two, guarded anyway).
- Control register, written at byte 0 when chipselect&&write, any address: bit0 lock, bit1 clear overrun (self-clearing strobe). Other bits ignored.
- Effective lock this cycle = (chipselect&&write) ? writedata[0] : lock_q.
- On frame_done: if the effective lock is 0, toggle bank_sel, increment frame_cnt (wraps), set ready; otherwise keep banks, set overrun sticky, increment drop_cnt (saturates at all-ones).
- bin_valid together with frame_done: the bin is written into the old back bank before the swap, i.e. included in the frame just published.
- Address map (bytes, word k little-endian, byte 0 = bits [7:0]):
  - 0 .. N_BINS*4-1: bins of the front bank. Bytes above WORD_W/8 return 0x00. Returns 0x00 while ready=0.
  - N_BINS*4 +0..3: frame_cnt latched at the last swap, zero-extended.
  - N_BINS*4 +4: status {5'b0, overrun, lock_q, ready}.
  - N_BINS*4 +8..11: drop_cnt.
  - All other addresses return 0x00.
- Reset: bank_sel=0, lock_q=0, ready=0, overrun=0, frame_cnt=0, drop_cnt=0, readdata=0x00. RAM contents are not reset; ready=0 masks them. Reset mid-frame discards the partial frame.

## Timing
- Read latency exactly 1 cycle: readdata in cycle n+1 reflects address in cycle n; reads need no chipselect (held value otherwise follows address).
- Bin write to visible in front bank: frame_done cycle + 1 for swap, +1 read latency.
- Swap takes effect in the cycle after frame_done; a read issued in the frame_done cycle returns the old front bank.
- lock_q updates the cycle after the write; status reflects it one read later.
- Clear-overrun and frame_done in the same cycle with lock set: overrun stays set (set wins).
- Continuous back-to-back frame_done pulses allowed, one per cycle minimum.

## Configuration
- READOUT_DROP_CNT_EN defined: drop_cnt implemented and mapped at N_BINS*4+8..11.
- Not defined: no drop_cnt register; those addresses return 0x00; overrun sticky still implemented.

## Structure
- Package sfft_readout_pkg: address offsets (OFS_CNT, OFS_STATUS, OFS_DROP relative to bin region end), status and control bit positions, status typedef struct.
- Sub-module readout_bank_ram: simple dual-port RAM of 2*N_BINS x WORD_W, bank bit as address MSB, one synchronous write port, one registered read port; byte select muxed after the RAM.

## Test plan
- Reset, read N_BINS*4+4 -> 0x00; read byte 0 -> 0x00 (ready=0).
- Stream bins k -> 0x0A0B0C00+k, frame_done -> status 0x01, byte 4*5+0 = 0x05, +3 = 0x0A, counter bytes 01 00 00 00.
- Write 0x01 (lock), stream and finish 3 frames -> front bins unchanged, status 0x07, drop_cnt 3; write 0x02 -> status 0x01 and lock released; next frame_done swaps, frame_cnt 2.
- frame_done in same cycle as lock write 0x01 -> frame dropped, drop_cnt +1; same cycle as unlock 0x00 -> swapped.
- bin_valid with frame_done on index N_BINS-1 -> that bin present in the published frame.
- Assert reset mid-frame after a published frame -> all outputs 0x00, subsequent full frame reads back correctly with frame_cnt 1; without READOUT_DROP_CNT_EN drop addresses read 0x00.
